// File: rtl/video_timing_gen_pkg.sv
// Shared raster constants for video_timing_gen: standard mode porch/sync sets,
// sync polarity constants and the blanking-start helper.
package video_timing_gen_pkg;

    localparam int POL_LOW  = 0;
    localparam int POL_HIGH = 1;

    typedef struct packed {
        int h_res;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_res;
        int v_fp;
        int v_sync;
        int v_bp;
        int h_pol;
        int v_pol;
    } timing_mode_t;

    localparam timing_mode_t MODE_480P = '{
        h_res: 640,  h_fp: 16,  h_sync: 96,  h_bp: 48,
        v_res: 480,  v_fp: 10,  v_sync: 2,   v_bp: 33,
        h_pol: POL_LOW,  v_pol: POL_LOW
    };

    localparam timing_mode_t MODE_600P = '{
        h_res: 800,  h_fp: 40,  h_sync: 128, h_bp: 88,
        v_res: 600,  v_fp: 1,   v_sync: 4,   v_bp: 23,
        h_pol: POL_HIGH, v_pol: POL_HIGH
    };

    localparam timing_mode_t MODE_720P = '{
        h_res: 1280, h_fp: 110, h_sync: 40,  h_bp: 220,
        v_res: 720,  v_fp: 5,   v_sync: 5,   v_bp: 20,
        h_pol: POL_HIGH, v_pol: POL_HIGH
    };

    // Blanking occupies negative coordinates, so the first position of a line
    // or frame is minus the total blanking length.
    function automatic int blank_start(input int fp, input int sync, input int bp);
        return -(fp + sync + bp);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register that latency-matches sync/DE to a pixel pipeline.
// DEPTH of 0 degenerates to a wire.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with clock enable, frame counter and a
// latency-matched copy of the sync/DE bus for pipelined renderers.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int H_RES    = MODE_480P.h_res,
    parameter int H_FP     = MODE_480P.h_fp,
    parameter int H_SYNC   = MODE_480P.h_sync,
    parameter int H_BP     = MODE_480P.h_bp,
    parameter int V_RES    = MODE_480P.v_res,
    parameter int V_FP     = MODE_480P.v_fp,
    parameter int V_SYNC   = MODE_480P.v_sync,
    parameter int V_BP     = MODE_480P.v_bp,
    parameter int H_POL    = MODE_480P.h_pol,
    parameter int V_POL    = MODE_480P.v_pol,
    parameter int PIPE_LAT = 2,
    parameter int FCNT_W   = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    en,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic [FCNT_W-1:0]       frame_cnt,
    output logic                    hsync_d,
    output logic                    vsync_d,
    output logic                    de_d
);

    localparam int H_STA_I = blank_start(H_FP, H_SYNC, H_BP);
    localparam int V_STA_I = blank_start(V_FP, V_SYNC, V_BP);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(H_STA_I + H_FP);
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + H_FP + H_SYNC - 1);
    localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(V_STA_I + V_FP);
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + V_FP + V_SYNC - 1);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    logic signed [CORDW-1:0] r_sx;
    logic signed [CORDW-1:0] r_sy;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_de;
    logic                    r_frame;
    logic                    r_line;
    logic [FCNT_W-1:0]       r_fcnt;

    logic signed [CORDW-1:0] w_sx_nxt;
    logic signed [CORDW-1:0] w_sy_nxt;
    logic                    w_line_end;
    logic                    w_frame_end;
    logic                    w_hsync_nxt;
    logic                    w_vsync_nxt;
    logic                    w_de_nxt;

    // Outputs are decoded from the next position so they land in the same
    // register stage as sx/sy and never lag them.
    always_comb begin
        w_line_end  = (r_sx == H_END);
        w_frame_end = w_line_end && (r_sy == V_END);
        w_sx_nxt    = w_line_end ? H_STA : r_sx + CORDW'(1);
        w_sy_nxt    = r_sy;
        if (w_line_end) begin
            w_sy_nxt = (r_sy == V_END) ? V_STA : r_sy + CORDW'(1);
        end
        w_hsync_nxt = (w_sx_nxt >= HS_BEG && w_sx_nxt <= HS_END) ? HS_ACT : ~HS_ACT;
        w_vsync_nxt = (w_sy_nxt >= VS_BEG && w_sy_nxt <= VS_END) ? VS_ACT : ~VS_ACT;
        w_de_nxt    = ~w_sx_nxt[CORDW-1] && ~w_sy_nxt[CORDW-1];
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_sx    <= H_STA;
            r_sy    <= V_STA;
            r_hsync <= ~HS_ACT;
            r_vsync <= ~VS_ACT;
            r_de    <= 1'b0;
            r_frame <= 1'b1;
            r_line  <= 1'b1;
            r_fcnt  <= '0;
        end else if (en) begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
            r_de    <= w_de_nxt;
            r_line  <= w_line_end;
            r_frame <= w_frame_end;
            if (w_frame_end) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    assign sx        = r_sx;
    assign sy        = r_sy;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign frame     = r_frame;
    assign line      = r_line;
    assign frame_cnt = r_fcnt;

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL ({~HS_ACT, ~VS_ACT, 1'b0})
    ) u_sync_delay (
        .clk (clk_pix),
        .rst (rst_pix),
        .en  (en),
        .i_d ({r_hsync, r_vsync, r_de}),
        .o_q ({hsync_d, vsync_d, de_d})
    );

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameter sets driven from one clock/enable,
// each compared every cycle against an arithmetic raster model.
module tb_video_timing_gen;

    typedef struct {
        int h_res, h_fp, h_sync, h_bp;
        int v_res, v_fp, v_sync, v_bp;
        int h_pol, v_pol, lat, fw;
    } cfg_t;

    logic   clk_pix = 1'b0;
    logic   rst_pix;
    logic   en;
    longint n;
    int     checks   = 0;
    int     failures = 0;
    cfg_t   cfgs [3];
    logic [63:0] dut_vec [3];

    always #5 clk_pix = ~clk_pix;

    // a: tiny, PIPE_LAT=3, FCNT_W=2
    logic signed [15:0] a_sx, a_sy;
    logic [1:0] a_fcnt;
    logic a_hs, a_vs, a_de, a_fr, a_ln, a_hsd, a_vsd, a_ded;
    // b: medium, PIPE_LAT=0, positive hsync
    logic signed [15:0] b_sx, b_sy;
    logic [15:0] b_fcnt;
    logic b_hs, b_vs, b_de, b_fr, b_ln, b_hsd, b_vsd, b_ded;
    // c: 480p defaults
    logic signed [15:0] c_sx, c_sy;
    logic [15:0] c_fcnt;
    logic c_hs, c_vs, c_de, c_fr, c_ln, c_hsd, c_vsd, c_ded;

    video_timing_gen #(
        .CORDW(16), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(1), .PIPE_LAT(3), .FCNT_W(2)
    ) dut_a (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en),
        .sx(a_sx), .sy(a_sy), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .frame(a_fr), .line(a_ln), .frame_cnt(a_fcnt),
        .hsync_d(a_hsd), .vsync_d(a_vsd), .de_d(a_ded)
    );

    video_timing_gen #(
        .CORDW(16), .H_RES(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_RES(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1), .V_POL(0), .PIPE_LAT(0), .FCNT_W(16)
    ) dut_b (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en),
        .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .frame(b_fr), .line(b_ln), .frame_cnt(b_fcnt),
        .hsync_d(b_hsd), .vsync_d(b_vsd), .de_d(b_ded)
    );

    video_timing_gen dut_c (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en),
        .sx(c_sx), .sy(c_sy), .hsync(c_hs), .vsync(c_vs), .de(c_de),
        .frame(c_fr), .line(c_ln), .frame_cnt(c_fcnt),
        .hsync_d(c_hsd), .vsync_d(c_vsd), .de_d(c_ded)
    );

    assign dut_vec[0] = {8'h0, a_sx, a_sy, 14'h0, a_fcnt,
                         a_hs, a_vs, a_de, a_fr, a_ln, a_hsd, a_vsd, a_ded};
    assign dut_vec[1] = {8'h0, b_sx, b_sy, b_fcnt,
                         b_hs, b_vs, b_de, b_fr, b_ln, b_hsd, b_vsd, b_ded};
    assign dut_vec[2] = {8'h0, c_sx, c_sy, c_fcnt,
                         c_hs, c_vs, c_de, c_fr, c_ln, c_hsd, c_vsd, c_ded};

    // Raster position after n enabled advances, decoded straight from the rules.
    function automatic logic [4:0] decode(input cfg_t c, input longint n_adv,
                                          output longint sx, output longint sy);
        longint htot, vtot, hsta, vsta;
        logic hs, vs;
        htot = c.h_res + c.h_fp + c.h_sync + c.h_bp;
        vtot = c.v_res + c.v_fp + c.v_sync + c.v_bp;
        hsta = -(c.h_fp + c.h_sync + c.h_bp);
        vsta = -(c.v_fp + c.v_sync + c.v_bp);
        sx = hsta + n_adv % htot;
        sy = vsta + (n_adv / htot) % vtot;
        hs = (sx >= hsta + c.h_fp && sx < hsta + c.h_fp + c.h_sync) ? (c.h_pol != 0) : (c.h_pol == 0);
        vs = (sy >= vsta + c.v_fp && sy < vsta + c.v_fp + c.v_sync) ? (c.v_pol != 0) : (c.v_pol == 0);
        return {hs, vs, (sx >= 0 && sy >= 0), (sx == hsta && sy == vsta), (sx == hsta)};
    endfunction

    function automatic logic [63:0] model(input cfg_t c, input longint n_adv);
        longint sx, sy, dsx, dsy, fc, ftot;
        logic [4:0] f, fd;
        logic [2:0] dl;
        f    = decode(c, n_adv, sx, sy);
        ftot = longint'(c.h_res + c.h_fp + c.h_sync + c.h_bp) *
               longint'(c.v_res + c.v_fp + c.v_sync + c.v_bp);
        fc   = (n_adv / ftot) % (longint'(1) << c.fw);
        if (n_adv < c.lat) begin
            dl = {(c.h_pol == 0), (c.v_pol == 0), 1'b0};
        end else begin
            fd = decode(c, n_adv - c.lat, dsx, dsy);
            dl = fd[4:2];
        end
        return {8'h0, sx[15:0], sy[15:0], fc[15:0], f, dl};
    endfunction

    task automatic tick(input logic e);
        en = e;
        @(posedge clk_pix);
        if (e && !rst_pix) n++;
        @(negedge clk_pix);
    endtask

    task automatic test_reset();
        logic [63:0] exp;
        rst_pix = 1'b1;
        en      = 1'b1;
        n       = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp = model(cfgs[k], 0);
            checks++;
            if (dut_vec[k] !== exp) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, dut_vec[k], exp);
            end
        end
        @(negedge clk_pix);
        rst_pix = 1'b0;
    endtask

    task automatic test_free_run();
        logic [63:0] exp;
        longint last_line = -1;
        for (int t = 0; t < 2 * 2072 + 20; t++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                exp = model(cfgs[k], n);
                checks++;
                if (dut_vec[k] !== exp) begin
                    failures++;
                    $display("FAIL free_run dut%0d n=%0d got=%h exp=%h", k, n, dut_vec[k], exp);
                end
            end
            if (c_ln) begin
                if (last_line >= 0) begin
                    checks++;
                    if (n - last_line != 800) begin
                        failures++;
                        $display("FAIL line_period got=%0d exp=800", n - last_line);
                    end
                end
                last_line = n;
            end
        end
        checks++;
        if (b_fcnt !== 16'd2) begin
            failures++;
            $display("FAIL frame_cnt_2 got=%0d exp=2", b_fcnt);
        end
    endtask

    task automatic test_enable_hold();
        logic [63:0] exp;
        rst_pix = 1'b1;
        #1;
        @(negedge clk_pix);
        rst_pix = 1'b0;
        n = 0;
        for (int t = 0; t < 26; t++) tick(1'b1);
        for (int t = 0; t < 6; t++) begin
            tick(t == 5);
            for (int k = 0; k < 3; k++) begin
                exp = model(cfgs[k], n);
                checks++;
                if (dut_vec[k] !== exp) begin
                    failures++;
                    $display("FAIL en_hold dut%0d n=%0d got=%h exp=%h", k, n, dut_vec[k], exp);
                end
            end
            checks++;
            if (b_sx !== ((t == 5) ? 16'sd11 : 16'sd10)) begin
                failures++;
                $display("FAIL en_hold_sx got=%0d exp=%0d", b_sx, (t == 5) ? 11 : 10);
            end
        end
    endtask

    task automatic test_random_enable();
        logic [63:0] exp;
        for (int t = 0; t < 3000; t++) begin
            tick($urandom_range(0, 3) != 0);
            for (int k = 0; k < 3; k++) begin
                exp = model(cfgs[k], n);
                checks++;
                if (dut_vec[k] !== exp) begin
                    failures++;
                    $display("FAIL rand_en dut%0d n=%0d got=%h exp=%h", k, n, dut_vec[k], exp);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] exp;
        for (int t = 0; t < 3; t++) tick(1'b1);
        #2;
        rst_pix = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp = model(cfgs[k], 0);
            checks++;
            if (dut_vec[k] !== exp) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", k, dut_vec[k], exp);
            end
        end
        @(negedge clk_pix);
        rst_pix = 1'b0;
        n = 0;
    endtask

    task automatic test_frame_wrap();
        logic [63:0] exp;
        for (int t = 0; t < 5 * 48; t++) tick(1'b1);
        checks++;
        if (a_fcnt !== 2'd1 || a_fr !== 1'b1) begin
            failures++;
            $display("FAIL frame_wrap got cnt=%0d frame=%b exp cnt=1 frame=1", a_fcnt, a_fr);
        end
        for (int k = 0; k < 3; k++) begin
            exp = model(cfgs[k], n);
            checks++;
            if (dut_vec[k] !== exp) begin
                failures++;
                $display("FAIL frame_wrap_state dut%0d n=%0d got=%h exp=%h", k, n, dut_vec[k], exp);
            end
        end
    endtask

    initial begin
        cfgs[0] = '{h_res: 4, h_fp: 1, h_sync: 2, h_bp: 1, v_res: 3, v_fp: 1, v_sync: 1, v_bp: 1,
                    h_pol: 0, v_pol: 1, lat: 3, fw: 2};
        cfgs[1] = '{h_res: 40, h_fp: 4, h_sync: 8, h_bp: 4, v_res: 30, v_fp: 2, v_sync: 2, v_bp: 3,
                    h_pol: 1, v_pol: 0, lat: 0, fw: 16};
        cfgs[2] = '{h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48, v_res: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                    h_pol: 0, v_pol: 0, lat: 2, fw: 16};
        test_reset();
        test_free_run();
        test_enable_hold();
        test_random_enable();
        test_async_reset();
        test_random_enable();
        test_async_reset();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
